ntp_set_loader: RTL



---
 rtl/ntp_pkg.sv | 15 +
 rtl/ntp_set_loader_if.sv | 26 ++
 rtl/ntp_byte_timer.sv | 29 ++
 rtl/ntp_set_loader.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ntp_pkg.sv
// Shared NTP definitions used by the set loader and the timestamp counter.
package ntp_pkg;

  localparam logic [63:0] NTP_US_STEP = 64'd4295;
  localparam int          NTP_BYTES   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ADD,
    ST_WAIT_SIG,
    ST_APPLY
  } ntp_ld_state_t;

endpackage

// File: rtl/ntp_set_loader_if.sv
// Host byte stream, boundary pulse and counter write bundle of the NTP set loader.
interface ntp_set_loader_if;

  logic        i_frame_start;
  logic        i_apply_on_sig;
  logic        i_byte_valid;
  logic [7:0]  i_byte_data;
  logic        o_byte_ready;
  logic        i_ntp_sig;
  logic [63:0] o_ntp_set;
  logic        o_ntp_set_sig;
  logic        o_busy;
  logic        o_done;
  logic        o_err_timeout;

  modport master (
    output i_frame_start, i_apply_on_sig, i_byte_valid, i_byte_data, i_ntp_sig,
    input  o_byte_ready, o_ntp_set, o_ntp_set_sig, o_busy, o_done, o_err_timeout
  );

  modport slave (
    input  i_frame_start, i_apply_on_sig, i_byte_valid, i_byte_data, i_ntp_sig,
    output o_byte_ready, o_ntp_set, o_ntp_set_sig, o_busy, o_done, o_err_timeout
  );

endinterface

// File: rtl/ntp_byte_timer.sv
// Clearable up-counter that flags BYTE_TIMEOUT-1 idle cycles between bytes.
module ntp_byte_timer #(
  parameter int BYTE_TIMEOUT = 50_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_term
);

  localparam int            TW   = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TW-1:0] TERM = TW'(BYTE_TIMEOUT - 1);

  logic [TW-1:0] r_count;

  // Saturates at the terminal value so it never wraps back into a quiet range
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (r_count != TERM) begin
      r_count <= r_count + TW'(1);
    end
  end

  assign o_term = (r_count == TERM);

endmodule

// File: rtl/ntp_set_loader.sv
// Collects an 8-byte NTP set frame, adds latency compensation and writes the counter.
module ntp_set_loader
  import ntp_pkg::*;
#(
  parameter int          BYTE_TIMEOUT = 50_000,
  parameter logic [63:0] LAT_COMP     = NTP_US_STEP * 64'd2
) (
  input logic             i_clk,
  input logic             i_rst,
  ntp_set_loader_if.slave bus
);

  localparam logic [2:0] LAST_BYTE = 3'(NTP_BYTES - 1);

  ntp_ld_state_t r_state;
  ntp_ld_state_t w_next_state;

  logic [63:0] r_sr;
  logic [63:0] r_ntp_set;
  logic [2:0]  r_count;
  logic        r_mode;
  logic        r_err_timeout;

  logic w_accept;
  logic w_restart;
  logic w_timeout;
  logic w_timer_clr;
  logic w_timer_term;

  ntp_byte_timer #(
    .BYTE_TIMEOUT(BYTE_TIMEOUT)
  ) u_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_timer_clr),
    .o_term(w_timer_term)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A frame start wins over a byte strobe in the same cycle
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_restart    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_frame_start) begin
          w_restart    = 1'b1;
          w_next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.i_frame_start) begin
          w_restart = 1'b1;
        end else if (bus.i_byte_valid) begin
          w_accept = 1'b1;
          if (r_count == LAST_BYTE) begin
            w_next_state = ST_ADD;
          end
        end else if (w_timer_term) begin
          w_timeout    = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      ST_ADD: begin
        w_next_state = r_mode ? ST_WAIT_SIG : ST_APPLY;
      end
      ST_WAIT_SIG: begin
        if (bus.i_frame_start) begin
          w_restart    = 1'b1;
          w_next_state = ST_LOAD;
        end else if (bus.i_ntp_sig) begin
          w_next_state = ST_APPLY;
        end
      end
      ST_APPLY: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    w_timer_clr = (r_state != ST_LOAD) || w_accept || w_restart;

    bus.o_byte_ready  = (r_state == ST_LOAD);
    bus.o_busy        = (r_state != ST_IDLE);
    bus.o_ntp_set_sig = (r_state == ST_APPLY);
    bus.o_done        = (r_state == ST_APPLY);
    bus.o_ntp_set     = r_ntp_set;
    bus.o_err_timeout = r_err_timeout;
  end

  // Compensated value is registered in ADD so it is stable before any strobe
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr          <= '0;
      r_ntp_set     <= '0;
      r_count       <= '0;
      r_mode        <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_err_timeout <= w_timeout;
      if (w_restart) begin
        r_mode  <= bus.i_apply_on_sig;
        r_count <= '0;
      end else if (w_accept) begin
        r_sr    <= {r_sr[55:0], bus.i_byte_data};
        r_count <= r_count + 3'd1;
      end
      if (r_state == ST_ADD) begin
        r_ntp_set <= r_sr + LAT_COMP;
      end
    end
  end

endmodule
